// File: rtl/uart_stream_master_pkg.sv
// Shared definitions for the APB master that bridges byte streams to a UART.
// Register map, status bit positions, operation and sequencer encodings.
package uart_stream_master_pkg;

    localparam logic [31:0] OFF_DATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STAT = 32'h0000_0004;
    localparam logic [31:0] OFF_BAUD = 32'h0000_0008;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_RX_EMPTY = 1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CFG,
        OP_RX,
        OP_TX,
        OP_POLL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    function automatic logic [31:0] op_offset(input op_e op);
        logic [31:0] off;
        case (op)
            OP_CFG:  off = OFF_BAUD;
            OP_POLL: off = OFF_STAT;
            default: off = OFF_DATA;
        endcase
        return off;
    endfunction

    function automatic logic op_is_write(input op_e op);
        return (op == OP_CFG) || (op == OP_TX);
    endfunction

endpackage

// File: rtl/uart_stream_master.sv
// APB master that polls a UART's status register and moves bytes between
// the UART data register and a pair of valid/ready byte streams.
module uart_stream_master
    import uart_stream_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  logic [19:0] cfg_baud_i,
    input  logic        cfg_baud_wr_i,
    output logic        err_o
);

    localparam logic [7:0] GAP = 8'(POLL_GAP);

    state_e      state_q, state_d;
    op_e         op_q, op_d, op_sel;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        cfg_pend_q, cfg_pend_d;
    logic [19:0] baud_q, baud_d;
    logic        stat_vld_q, stat_vld_d;
    logic        rx_empty_q, rx_empty_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  poll_q, poll_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        err_q, err_d;
    logic        done;
    logic        unused_prdata;

    assign unused_prdata = ^prdata[31:8];
    assign done = (state_q == ST_ACCESS) && pready;

    // Strict priority: config, drain RX, feed TX, then status refresh.
    always_comb begin
        op_sel = OP_NONE;
        priority case (1'b1)
            cfg_pend_q:
                op_sel = OP_CFG;
            (stat_vld_q && !rx_empty_q && !rx_valid_q):
                op_sel = OP_RX;
            (stat_vld_q && !tx_full_q && tx_valid_i):
                op_sel = OP_TX;
            ((poll_q == 8'd0) || !stat_vld_q):
                op_sel = OP_POLL;
            default:
                op_sel = OP_NONE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        cfg_pend_d = cfg_pend_q;
        baud_d     = baud_q;
        stat_vld_d = stat_vld_q;
        rx_empty_d = rx_empty_q;
        tx_full_d  = tx_full_q;
        poll_d     = poll_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (poll_q != 8'd0) poll_d = poll_q - 8'd1;
                if (op_sel != OP_NONE) begin
                    state_d  = ST_SETUP;
                    op_d     = op_sel;
                    paddr_d  = BASE_ADDR + op_offset(op_sel);
                    pwrite_d = op_is_write(op_sel);
                    case (op_sel)
                        OP_CFG:  pwdata_d = {12'b0, baud_q};
                        OP_TX:   pwdata_d = {24'b0, tx_data_i};
                        default: pwdata_d = 32'h0;
                    endcase
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    state_d = ST_IDLE;
                    op_d    = OP_NONE;
                    if (pslverr) err_d = 1'b1;
                    case (op_q)
                        OP_CFG: cfg_pend_d = 1'b0;
                        OP_RX: begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = prdata[7:0];
                            stat_vld_d = 1'b0;
                        end
                        OP_TX: stat_vld_d = 1'b0;
                        OP_POLL: begin
                            stat_vld_d = 1'b1;
                            rx_empty_d = prdata[STAT_RX_EMPTY];
                            tx_full_d  = prdata[STAT_TX_FULL];
                            poll_d     = GAP;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

        // A fresh request wins over clearing, so a value landing while the
        // previous one is being written still gets its own write.
        if (cfg_baud_wr_i) begin
            cfg_pend_d = 1'b1;
            baud_d     = cfg_baud_i;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            pwrite_q   <= 1'b0;
            cfg_pend_q <= 1'b0;
            baud_q     <= 20'h0;
            stat_vld_q <= 1'b0;
            rx_empty_q <= 1'b0;
            tx_full_q  <= 1'b0;
            poll_q     <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            cfg_pend_q <= cfg_pend_d;
            baud_q     <= baud_d;
            stat_vld_q <= stat_vld_d;
            rx_empty_q <= rx_empty_d;
            tx_full_q  <= tx_full_d;
            poll_q     <= poll_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
        end
    end

    assign psel       = (state_q != ST_IDLE);
    assign penable    = (state_q == ST_ACCESS);
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = done && (op_q == OP_TX);
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_stream_master.sv
// Bench for uart_stream_master: UART slave model on APB, stream source/sink,
// scenario table, directed corner sequences and a randomized traffic run.
module tb_uart_stream_master;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int GAP = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [7:0]  rx_data_o, tx_data_i;
    logic        rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o;
    logic [19:0] cfg_baud_i;
    logic        cfg_baud_wr_i, err_o;

    always #5 pclk = ~pclk;

    uart_stream_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .cfg_baud_i(cfg_baud_i), .cfg_baud_wr_i(cfg_baud_wr_i), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic [7:0]  rxq[$], txsrc[$], popped[$], rx_got[$], tx_log[$];
    logic [7:0]  rx_orig[$], tx_orig[$];
    logic [31:0] baud_log[$];
    xfer_t       xlog[$];
    int          poll_setup_cyc[$];
    int  stall_cfg, stall_left, full_mode;
    bit  stall_rand, err_rand, rdy_rand, rdy_cfg, slverr_cfg;
    bit  full_cur, rx_ok, tx_ok, exp_err;
    int  cyc, n_rd0, n_wr0, n_poll, tx_pulses, rxv_cycles;
    logic [31:0] s_addr, s_wdata;
    logic        s_wr;

    // Slave side of a completing transfer: the UART register file plus the
    // rule that data accesses need a status read that allowed them.
    task automatic complete();
        logic [31:0] off;
        xfer_t x;
        off = paddr - BASE;
        x.addr = paddr;
        x.wr = pwrite;
        x.data = pwrite ? pwdata : prdata;
        xlog.push_back(x);
        if (pslverr) exp_err = 1'b1;
        if (off == 32'h0 && !pwrite) begin
            n_rd0++;
            chk("rx_read_needs_nonempty_status", rx_ok, 1);
            chk("rx_read_while_valid", rx_valid_o, 0);
            if (rxq.size() > 0) popped.push_back(rxq.pop_front());
            rx_ok = 0;
            tx_ok = 0;
        end else if (off == 32'h0 && pwrite) begin
            n_wr0++;
            chk("tx_write_needs_notfull_status", tx_ok, 1);
            chk("tx_wdata_upper_zero", pwdata[31:8], 0);
            tx_log.push_back(pwdata[7:0]);
            rx_ok = 0;
            tx_ok = 0;
        end else if (off == 32'h8 && pwrite) begin
            baud_log.push_back(pwdata);
        end else if (off == 32'h4 && !pwrite) begin
            n_poll++;
            rx_ok = rxq.size() > 0;
            tx_ok = !full_cur;
        end else begin
            checks++;
            errors++;
            $display("FAIL bad_access: addr %0h write %0b", paddr, pwrite);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        cyc++;
        tx_valid_i = txsrc.size() > 0;
        tx_data_i  = (txsrc.size() > 0) ? txsrc[0] : 8'h00;
        rx_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_cfg;
        if (psel && !penable) begin
            s_addr = paddr;
            s_wr = pwrite;
            s_wdata = pwdata;
            if (paddr == BASE + 32'd4 && !pwrite) begin
                poll_setup_cyc.push_back(cyc);
                full_cur = (full_mode == 2) ? ($urandom_range(0, 2) == 0) : (full_mode == 1);
            end
        end
        if (psel && penable) begin
            chk("apb_hold_addr", paddr, s_addr);
            chk("apb_hold_write", pwrite, s_wr);
            chk("apb_hold_wdata", pwdata, s_wdata);
            if (stall_left > 0) begin
                pready = 1'b0;
                stall_left--;
            end else begin
                pready = 1'b1;
            end
        end else begin
            pready = 1'b0;
            stall_left = stall_rand ? int'($urandom_range(0, 3)) : stall_cfg;
        end
        prdata = 32'h0;
        if (psel && !pwrite) begin
            if (paddr == BASE)
                prdata = (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'h0;
            else if (paddr == BASE + 32'd4)
                prdata = {30'h0, rxq.size() == 0, full_cur};
        end
        pslverr = psel && penable && pready &&
                  (err_rand ? ($urandom_range(0, 7) == 0) : slverr_cfg);
        #1;
        if (psel && penable && pready) complete();
        if (tx_valid_i && tx_ready_o) begin
            tx_pulses++;
            void'(txsrc.pop_front());
        end
        if (rx_valid_o) begin
            rxv_cycles++;
            if (rx_ready_i) rx_got.push_back(rx_data_o);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        cfg_baud_wr_i = 1'b0;
        cfg_baud_i = 20'h0;
        rxq.delete(); txsrc.delete(); popped.delete(); rx_got.delete();
        tx_log.delete(); baud_log.delete(); xlog.delete(); poll_setup_cyc.delete();
        rx_orig.delete(); tx_orig.delete();
        stall_cfg = 0; stall_rand = 0; err_rand = 0; rdy_rand = 0;
        rdy_cfg = 1; slverr_cfg = 0; full_mode = 0; full_cur = 0;
        rx_ok = 0; tx_ok = 0; exp_err = 0;
        n_rd0 = 0; n_wr0 = 0; n_poll = 0; tx_pulses = 0; rxv_cycles = 0;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int nrx; logic [7:0] rb0; logic [7:0] rb1; bit rdy;
        bit txv; logic [7:0] txd; bit full; bit serr;
        int e_rd0; int e_wr0; int e_got; int e_rxv; int e_txp;
        bit e_err; bit e_vend;
    } row_t;

    row_t rows[7];

    initial begin
        int n;
        bit found;
        prdata = 0; pready = 0; pslverr = 0;
        rx_ready_i = 0; tx_valid_i = 0; tx_data_i = 0;
        cfg_baud_i = 0; cfg_baud_wr_i = 0;
        cyc = 0;

        rows[0] = '{0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        rows[1] = '{1, 8'hA5, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0, 0};
        rows[2] = '{0, 8'h00, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        rows[3] = '{0, 8'h00, 8'h00, 1, 1, 8'h3C, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        rows[4] = '{2, 8'h11, 8'h22, 0, 0, 8'h00, 0, 0, 1, 0, 0, -1, 0, 0, 1};
        rows[5] = '{1, 8'h5A, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 1, 1, 0, 1, 0};
        rows[6] = '{0, 8'h00, 8'h00, 1, 1, 8'h77, 0, 1, 0, 1, 0, 0, 1, 1, 0};

        for (int r = 0; r < 7; r++) begin
            reset_dut();
            rdy_cfg = rows[r].rdy;
            full_mode = rows[r].full ? 1 : 0;
            slverr_cfg = rows[r].serr;
            if (rows[r].nrx > 0) rxq.push_back(rows[r].rb0);
            if (rows[r].nrx > 1) rxq.push_back(rows[r].rb1);
            if (rows[r].txv) txsrc.push_back(rows[r].txd);
            repeat (60) tick();
            chk($sformatf("row%0d_rd0", r), n_rd0, rows[r].e_rd0);
            chk($sformatf("row%0d_wr0", r), n_wr0, rows[r].e_wr0);
            chk($sformatf("row%0d_rx_got", r), rx_got.size(), rows[r].e_got);
            chk($sformatf("row%0d_tx_pulses", r), tx_pulses, rows[r].e_txp);
            chk($sformatf("row%0d_err", r), err_o, rows[r].e_err);
            chk($sformatf("row%0d_rx_valid_end", r), rx_valid_o, rows[r].e_vend);
            chk($sformatf("row%0d_polled", r), n_poll > 0, 1);
            if (rows[r].e_rxv >= 0)
                chk($sformatf("row%0d_rxv_cycles", r), rxv_cycles, rows[r].e_rxv);
            if (rows[r].e_got > 0 && rx_got.size() > 0)
                chk($sformatf("row%0d_rx_byte", r), rx_got[0], rows[r].rb0);
            if (rows[r].e_wr0 > 0 && tx_log.size() > 0)
                chk($sformatf("row%0d_tx_byte", r), tx_log[0], rows[r].txd);
            if (rows[r].e_vend)
                chk($sformatf("row%0d_rx_data_held", r), rx_data_o, rows[r].rb0);
        end

        // Idle polling cadence with an empty, non-full UART.
        reset_dut();
        repeat (40) tick();
        chk("poll_count", poll_setup_cyc.size() >= 4, 1);
        for (int i = 1; i < 4 && i < poll_setup_cyc.size(); i++)
            chk("poll_spacing", poll_setup_cyc[i] - poll_setup_cyc[i-1], GAP + 3);
        chk("poll_only_status", n_rd0 + n_wr0 + baud_log.size(), 0);

        // Two baud requests during a stalled access: only the last is written,
        // and it is the very next transfer.
        reset_dut();
        stall_cfg = 5;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = psel && penable && !pready;
        end
        chk("baud_found_stall", found, 1);
        n = xlog.size();
        cfg_baud_i = 20'd99;
        cfg_baud_wr_i = 1'b1;
        tick();
        cfg_baud_i = 20'd54;
        tick();
        cfg_baud_wr_i = 1'b0;
        repeat (40) tick();
        chk("baud_xfers", xlog.size() >= n + 2, 1);
        if (xlog.size() >= n + 2) begin
            chk("baud_next_addr", xlog[n+1].addr, BASE + 32'd8);
            chk("baud_next_write", xlog[n+1].wr, 1);
            chk("baud_next_data", xlog[n+1].data, 32'd54);
        end
        chk("baud_write_count", baud_log.size(), 1);

        // Reset landing in the middle of a TX write access.
        reset_dut();
        stall_cfg = 8;
        txsrc.push_back(8'h3C);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = psel && penable && pwrite && (paddr == BASE);
        end
        chk("abort_found_access", found, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        chk("abort_tx_ready", tx_ready_o, 0);
        chk("abort_rx_valid", rx_valid_o, 0);
        repeat (3) tick();
        chk("abort_no_tx_handshake", tx_pulses, 0);
        chk("abort_no_tx_write", n_wr0, 0);

        // Randomized traffic in both directions with stalls, errors,
        // backpressure and a flickering tx_full.
        reset_dut();
        stall_rand = 1;
        err_rand = 1;
        rdy_rand = 1;
        full_mode = 2;
        for (int i = 0; i < 24; i++) begin
            rx_orig.push_back(8'($urandom));
            tx_orig.push_back(8'($urandom));
        end
        foreach (rx_orig[i]) rxq.push_back(rx_orig[i]);
        foreach (tx_orig[i]) txsrc.push_back(tx_orig[i]);
        found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            tick();
            found = (rx_got.size() >= 24) && (tx_log.size() >= 24);
        end
        chk("rand_finished", found, 1);
        chk("rand_rx_count", rx_got.size(), 24);
        chk("rand_tx_count", tx_log.size(), 24);
        chk("rand_tx_pulses", tx_pulses, 24);
        for (int i = 0; i < 24 && i < rx_got.size(); i++)
            chk($sformatf("rand_rx_byte%0d", i), rx_got[i], rx_orig[i]);
        for (int i = 0; i < 24 && i < tx_log.size(); i++)
            chk($sformatf("rand_tx_byte%0d", i), tx_log[i], tx_orig[i]);
        chk("rand_err", err_o, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_stream_master.md
UART_STREAM_MASTER -- requirements
Module: uart_stream_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, APB base address of the target UART.
REQ-002 Parameter POLL_GAP, default 4, idle pclk cycles between successive status polls (range 0..255).
REQ-003 pclk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 paddr  out  32  APB address.
REQ-006 psel, penable, pwrite  out  1 each  APB master controls.
REQ-007 pwdata  out  32  APB write data.
REQ-008 prdata  in  32  APB read data.
REQ-009 pready, pslverr  in  1 each  APB completion and error.
REQ-010 rx_data_o  out  8  received byte to the consumer.
REQ-011 rx_valid_o / rx_ready_i  out / in  1  RX stream handshake.
REQ-012 tx_data_i  in  8  byte to transmit.
REQ-013 tx_valid_i / tx_ready_o  in / out  1  TX stream handshake.
REQ-014 cfg_baud_i  in  20  baud divisor value.
REQ-015 cfg_baud_wr_i  in  1  one-cycle request to write cfg_baud_i.
REQ-016 err_o  out  1  sticky: any pslverr seen.

Function
REQ-017 Target register map, offsets from BASE_ADDR: 0x00 data (write = TX push, read = RX pop, byte in [7:0]); 0x04 status (bit1 rx_empty, bit0 tx_full); 0x08 baud divisor [19:0].
REQ-018 APB FSM states: IDLE (psel=0) -> SETUP (psel=1, penable=0, one cycle) -> ACCESS (psel=1, penable=1, held until pready=1) -> IDLE.
REQ-019 paddr, pwrite, pwdata are set on entry to SETUP and held constant through ACCESS.
REQ-020 Minimum transfer cost: 3 cycles (IDLE, SETUP, ACCESS); every pready=0 cycle in ACCESS adds one.
REQ-021 cfg_baud_wr_i latches cfg_baud_i and sets cfg_pend; a second request before service overwrites the value (one write issued).
REQ-022 Cached status: stat_vld, rx_empty_c, tx_full_c; loaded on completion of a status read; stat_vld cleared on completion of any data-register access.
REQ-023 Operation selection in IDLE, strict priority: (1) cfg_pend -> write 0x08, pwdata={12'b0,baud}; (2) stat_vld & !rx_empty_c & !rx_valid_o -> read 0x00; (3) stat_vld & !tx_full_c & tx_valid_i -> write 0x00, pwdata={24'b0,tx_data_i}; (4) poll counter expired or !stat_vld -> read 0x04 (subject to REQ-024); else remain IDLE.
REQ-024 Poll counter reloads to POLL_GAP on each status-read completion, decrements per IDLE cycle; poll allowed at 0; POLL_GAP=0 means back-to-back polls.
REQ-025 cfg_pend cleared on completion of the 0x08 write.
REQ-026 RX read completion: rx_data_o<=prdata[7:0], rx_valid_o<=1 next cycle; held stable until rx_valid_o & rx_ready_i, then rx_valid_o<=0.
REQ-027 tx_ready_o=1 exactly in the ACCESS cycle with pready=1 of a 0x00 write; otherwise 0; tx_data_i must remain stable while tx_valid_i=1 and unaccepted.
REQ-028 pslverr=1 at completion sets err_o; transfer treated as complete (RX byte still delivered, TX byte still consumed).
REQ-029 Stream backpressure: rx_valid_o high blocks further RX reads; TX traffic and polls continue.

Reset
REQ-030 On rst_n low: FSM IDLE; psel, penable, pwrite=0; paddr, pwdata=0; rx_valid_o, rx_data_o, tx_ready_o, err_o=0; cfg_pend, stat_vld=0; poll counter=0.
REQ-031 Reset during SETUP/ACCESS aborts the transfer immediately; no partial stream handshake is produced.

Structure
REQ-032 Shared package holds register offsets (0x00/0x04/0x08), status bit indices, op-select encoding and FSM state typedef.
REQ-033 Single module; no sub-module is natural, because the APB sequencer and the stream buffers are tightly coupled.

Verification
REQ-034 Reset, then release with the slave holding status=0x2 (rx_empty=1, tx_full=0) and no streams active -> repeated reads of 0x04 spaced by POLL_GAP=4 idle cycles; no other accesses.
REQ-035 Slave status=0x0, prdata at 0x00=0xA5, rx_ready_i=1 -> one read of 0x00; rx_valid_o=1 with rx_data_o=0xA5 for one cycle.
REQ-036 tx_valid_i=1, tx_data_i=0x3C, status tx_full=0 -> write 0x00 with pwdata=0x3C; tx_ready_o pulses once; with status tx_full=1 -> no write issued.
REQ-037 cfg_baud_wr_i with cfg_baud_i=20'd54 pulsed during an ACCESS stalled 5 cycles by pready=0 -> 0x08 write of 54 issued directly after the current transfer completes.
REQ-038 rx_ready_i=0 with byte 0x11 pending and status rx_empty=0 -> no second 0x00 read until the handshake; pslverr=1 on any transfer -> err_o=1 until reset.
REQ-039 rst_n asserted mid-ACCESS -> psel=0 same cycle; tx_ready_o and rx_valid_o remain 0.
